// File: rtl/vend_dispense_if.sv
// rtl/vend_dispense_if.sv - request, sensor and actuator bundle for vend_dispense_sequencer
interface vend_dispense_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_candy;
    logic [2:0] req_change_beg;
    logic       req_change_obeg;
    logic       dispensed_sense;
    logic       fault_clr;
    logic       candy_motor;
    logic       beg_motor;
    logic       obeg_motor;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_item;
    logic [3:0] items_left;

    modport master (
        output req_valid, req_candy, req_change_beg, req_change_obeg,
        output dispensed_sense, fault_clr,
        input  req_ready, candy_motor, beg_motor, obeg_motor,
        input  busy, done, fault, fault_item, items_left
    );

    modport slave (
        input  req_valid, req_candy, req_change_beg, req_change_obeg,
        input  dispensed_sense, fault_clr,
        output req_ready, candy_motor, beg_motor, obeg_motor,
        output busy, done, fault, fault_item, items_left
    );
endinterface

// File: rtl/vend_dispense_sequencer.sv
// rtl/vend_dispense_sequencer.sv - one-unit-at-a-time candy/coin dispense sequencer with drop-sensor jam detection
module vend_dispense_sequencer #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset,
    vend_dispense_if.slave  bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PULSE      = 3'd1;
    localparam logic [2:0] S_WAIT_SENSE = 3'd2;
    localparam logic [2:0] S_GAP        = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;
    localparam logic [2:0] S_FAULT      = 3'd5;

    // Item codes double as the fault_item encoding.
    localparam logic [1:0] IT_NONE  = 2'b00;
    localparam logic [1:0] IT_CANDY = 2'b01;
    localparam logic [1:0] IT_BEG   = 2'b10;
    localparam logic [1:0] IT_OBEG  = 2'b11;

    localparam logic [4:0] PULSE_LAST   = 5'(PULSE_LEN - 1);
    localparam logic [4:0] GAP_LAST     = 5'(GAP_LEN - 1);
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

    logic [2:0] state_q,      state_d;
    logic [4:0] cnt_q,        cnt_d;
    logic [2:0] candy_cnt_q,  candy_cnt_d;
    logic [2:0] beg_cnt_q,    beg_cnt_d;
    logic       obeg_q,       obeg_d;
    logic [1:0] item_q,       item_d;
    logic       seen_q,       seen_d;
    logic [3:0] items_left_q, items_left_d;
    logic [1:0] fault_item_q, fault_item_d;

    logic       go_gap;
    logic [1:0] next_item;

    // Fixed dispense order: candies first, then big coins, then the small coin.
    function automatic logic [1:0] pick_item(input logic [2:0] c, input logic [2:0] b,
                                             input logic o);
        if (c != 3'd0)      return IT_CANDY;
        else if (b != 3'd0) return IT_BEG;
        else if (o)         return IT_OBEG;
        else                return IT_NONE;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        candy_cnt_d  = candy_cnt_q;
        beg_cnt_d    = beg_cnt_q;
        obeg_d       = obeg_q;
        item_d       = item_q;
        seen_d       = seen_q;
        items_left_d = items_left_q;
        fault_item_d = fault_item_q;
        go_gap       = 1'b0;
        next_item    = pick_item(candy_cnt_q, beg_cnt_q, obeg_q);

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    candy_cnt_d  = bus.req_candy;
                    beg_cnt_d    = bus.req_change_beg;
                    obeg_d       = bus.req_change_obeg;
                    items_left_d = 4'(bus.req_candy) + 4'(bus.req_change_beg)
                                 + 4'(bus.req_change_obeg);
                    cnt_d        = 5'd0;
                    seen_d       = 1'b0;
                    item_d       = pick_item(bus.req_candy, bus.req_change_beg,
                                             bus.req_change_obeg);
                    state_d      = (item_d == IT_NONE) ? S_DONE : S_PULSE;
                end
            end

            S_PULSE: begin
                if (bus.dispensed_sense) begin
                    seen_d = 1'b1;
                end
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = 5'd0;
                    if (seen_q || bus.dispensed_sense) begin
                        go_gap = 1'b1;
                    end else begin
                        state_d = S_WAIT_SENSE;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_WAIT_SENSE: begin
                if (bus.dispensed_sense) begin
                    go_gap = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = S_FAULT;
                    fault_item_d = item_q;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 5'd0;
                    item_d  = next_item;
                    state_d = (next_item == IT_NONE) ? S_DONE : S_PULSE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                if (bus.fault_clr) begin
                    state_d      = S_IDLE;
                    candy_cnt_d  = 3'd0;
                    beg_cnt_d    = 3'd0;
                    obeg_d       = 1'b0;
                    items_left_d = 4'd0;
                    item_d       = IT_NONE;
                    fault_item_d = IT_NONE;
                    seen_d       = 1'b0;
                    cnt_d        = 5'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A confirmed unit retires here so items_left drops on GAP entry.
        if (go_gap) begin
            state_d      = S_GAP;
            cnt_d        = 5'd0;
            seen_d       = 1'b0;
            items_left_d = items_left_q - 4'd1;
            case (item_q)
                IT_CANDY: candy_cnt_d = candy_cnt_q - 3'd1;
                IT_BEG:   beg_cnt_d   = beg_cnt_q - 3'd1;
                IT_OBEG:  obeg_d      = 1'b0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            candy_cnt_q  <= 3'd0;
            beg_cnt_q    <= 3'd0;
            obeg_q       <= 1'b0;
            item_q       <= IT_NONE;
            seen_q       <= 1'b0;
            items_left_q <= 4'd0;
            fault_item_q <= IT_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            candy_cnt_q  <= candy_cnt_d;
            beg_cnt_q    <= beg_cnt_d;
            obeg_q       <= obeg_d;
            item_q       <= item_d;
            seen_q       <= seen_d;
            items_left_q <= items_left_d;
            fault_item_q <= fault_item_d;
        end
    end

    // Every output is a decode of registered state only.
    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.fault_item  = fault_item_q;
    assign bus.items_left  = items_left_q;
    assign bus.candy_motor = (state_q == S_PULSE) && (item_q == IT_CANDY);
    assign bus.beg_motor   = (state_q == S_PULSE) && (item_q == IT_BEG);
    assign bus.obeg_motor  = (state_q == S_PULSE) && (item_q == IT_OBEG);

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// tb/tb_vend_dispense_sequencer.sv - randomized self-checking bench against a timeline model
module tb_vend_dispense_sequencer;
    localparam int P    = 4;
    localparam int G    = 2;
    localparam int T    = 16;
    localparam int MAXC = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vend_dispense_if bus();

    vend_dispense_sequencer #(.PULSE_LEN(P), .GAP_LEN(G), .TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // plan[u]: cycle of unit u's sensor pulse counted from its first motor cycle (1-based).
    // 1..P lands inside the pulse, P+1..P+T in the wait window, anything later is a jam.
    int plan[16];

    logic [2:0] e_mot  [MAXC];
    int         e_left [MAXC];
    bit         e_done [MAXC];
    bit         e_busy [MAXC];
    bit         e_sense[MAXC];
    int         e_len;
    int         fault_at;
    logic [1:0] e_fitem;

    task automatic build_model(input int c, input int b, input int o);
        int units[$];
        int cyc;
        int left;
        for (int i = 0; i < MAXC; i++) begin
            e_mot[i] = 3'b000; e_left[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_sense[i] = 0;
        end
        for (int i = 0; i < c; i++) units.push_back(1);
        for (int i = 0; i < b; i++) units.push_back(2);
        for (int i = 0; i < o; i++) units.push_back(3);
        cyc = 1; left = c + b + o; fault_at = 0; e_fitem = 2'b00;
        for (int u = 0; u < units.size(); u++) begin
            logic [2:0] mv;
            int d;
            mv = (units[u] == 1) ? 3'b100 : (units[u] == 2) ? 3'b010 : 3'b001;
            d  = plan[u];
            for (int k = 0; k < P; k++) begin
                e_mot[cyc+k] = mv; e_left[cyc+k] = left; e_busy[cyc+k] = 1;
            end
            if (d <= P) begin
                e_sense[cyc+d-1] = 1;
                cyc += P;
            end else begin
                int w;
                cyc += P;
                w = (d - P <= T) ? d - P : T;
                for (int k = 0; k < w; k++) begin
                    e_left[cyc+k] = left; e_busy[cyc+k] = 1;
                end
                if (d - P <= T) begin
                    e_sense[cyc+w-1] = 1;
                    cyc += w;
                end else begin
                    cyc += T;
                    fault_at = cyc;
                    e_fitem  = 2'(units[u]);
                    e_len    = cyc;
                    return;
                end
            end
            left--;
            for (int k = 0; k < G; k++) begin
                e_left[cyc+k] = left; e_busy[cyc+k] = 1;
                e_sense[cyc+k] = 1'($urandom_range(0, 1));
            end
            cyc += G;
        end
        e_done[cyc] = 1; e_busy[cyc] = 1; e_left[cyc] = 0;
        cyc++;
        e_len = cyc;
    endtask

    task automatic run_and_check_txn(input int c, input int b, input int o, input bit hold);
        int last;
        bus.fault_clr = 1'b0;
        bus.dispensed_sense = 1'b0;
        build_model(c, b, o);
        bus.req_candy = 3'(c); bus.req_change_beg = 3'(b); bus.req_change_obeg = 1'(o);
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        last = (fault_at != 0) ? fault_at - 1 : e_len;
        for (int k = 1; k <= last; k++) begin
            bus.dispensed_sense = e_sense[k];
            bus.fault_clr = 1'($urandom_range(0, 1));
            if (hold) begin
                bus.req_candy = 3'($urandom); bus.req_change_beg = 3'($urandom);
                bus.req_change_obeg = 1'($urandom);
            end
            checks++;
            if ({bus.candy_motor, bus.beg_motor, bus.obeg_motor} !== e_mot[k]) begin
                errors++;
                $display("FAIL motors cyc=%0d got=%b exp=%b", k,
                         {bus.candy_motor, bus.beg_motor, bus.obeg_motor}, e_mot[k]);
            end
            checks++;
            if (bus.items_left !== 4'(e_left[k])) begin
                errors++;
                $display("FAIL items_left cyc=%0d got=%0d exp=%0d", k, bus.items_left, e_left[k]);
            end
            checks++;
            if (bus.done !== e_done[k]) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", k, bus.done, e_done[k]);
            end
            checks++;
            if (bus.busy !== e_busy[k] || bus.req_ready !== !e_busy[k]) begin
                errors++;
                $display("FAIL busy_ready cyc=%0d got=%b/%b exp=%b/%b", k, bus.busy,
                         bus.req_ready, e_busy[k], !e_busy[k]);
            end
            checks++;
            if (bus.fault !== 1'b0) begin
                errors++;
                $display("FAIL fault_early cyc=%0d got=%b exp=0", k, bus.fault);
            end
            if (k < last) begin
                @(posedge clk); #1;
            end
        end
        if (fault_at != 0) begin
            @(posedge clk); #1;
            for (int f = 0; f < 3; f++) begin
                bus.dispensed_sense = 1'($urandom_range(0, 1));
                bus.fault_clr = 1'b0;
                checks++;
                if (bus.fault !== 1'b1 || bus.fault_item !== e_fitem) begin
                    errors++;
                    $display("FAIL fault_state f=%0d got=%b/%b exp=1/%b", f, bus.fault,
                             bus.fault_item, e_fitem);
                end
                checks++;
                if ({bus.candy_motor, bus.beg_motor, bus.obeg_motor, bus.done, bus.req_ready,
                     bus.busy} !== 6'b000001) begin
                    errors++;
                    $display("FAIL fault_outputs f=%0d got=%b exp=000001", f,
                             {bus.candy_motor, bus.beg_motor, bus.obeg_motor, bus.done,
                              bus.req_ready, bus.busy});
                end
                if (f < 2) begin
                    @(posedge clk); #1;
                end
            end
            bus.fault_clr = 1'b1;
            @(posedge clk); #1;
            bus.fault_clr = 1'b0;
            checks++;
            if ({bus.req_ready, bus.busy, bus.fault, bus.fault_item, bus.done, bus.items_left}
                !== 10'b10_0_00_0_0000) begin
                errors++;
                $display("FAIL fault_clear got=%b exp=1000000000",
                         {bus.req_ready, bus.busy, bus.fault, bus.fault_item, bus.done,
                          bus.items_left});
            end
        end
        bus.dispensed_sense = 1'b0;
        bus.fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.fault, bus.fault_item, bus.items_left,
             bus.candy_motor, bus.beg_motor, bus.obeg_motor} !== 13'b1_0_0_0_00_0000_000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=1000000000000",
                     {bus.req_ready, bus.busy, bus.done, bus.fault, bus.fault_item,
                      bus.items_left, bus.candy_motor, bus.beg_motor, bus.obeg_motor});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_candy();
        plan[0] = 2;
        run_and_check_txn(1, 0, 0, 1'b0);
    endtask

    task automatic test_mixed_order();
        for (int i = 0; i < 4; i++) plan[i] = $urandom_range(1, P + T);
        run_and_check_txn(2, 1, 1, 1'b0);
    endtask

    task automatic test_zero_request();
        run_and_check_txn(0, 0, 0, 1'b0);
    endtask

    task automatic test_jam_fault();
        plan[0] = P + T + 5;
        run_and_check_txn(0, 2, 0, 1'b0);
    endtask

    task automatic test_sense_window();
        plan[0] = P + 5;
        run_and_check_txn(1, 0, 0, 1'b0);
        plan[0] = P + T;
        run_and_check_txn(1, 0, 0, 1'b0);
        plan[0] = P + T + 1;
        run_and_check_txn(1, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_pulse();
        bus.req_candy = 3'd1; bus.req_change_beg = 3'd0; bus.req_change_obeg = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.candy_motor !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_motor got=%b exp=1", bus.candy_motor);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({bus.candy_motor, bus.busy, bus.req_ready, bus.items_left} !== 7'b0_0_1_0000) begin
            errors++;
            $display("FAIL reset_mid_pulse got=%b exp=0010000",
                     {bus.candy_motor, bus.busy, bus.req_ready, bus.items_left});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.candy_motor, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_discard got=%b exp=00", {bus.candy_motor, bus.busy});
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) plan[i] = $urandom_range(1, P + T);
            run_and_check_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                              1'b1);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                plan[i] = ($urandom_range(0, 19) == 0) ? P + T + 1 + $urandom_range(0, 3)
                                                       : $urandom_range(1, P + T);
            end
            run_and_check_txn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                              1'b0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_candy = 3'd0;
        bus.req_change_beg = 3'd0;
        bus.req_change_obeg = 1'b0;
        bus.dispensed_sense = 1'b0;
        bus.fault_clr = 1'b0;
        test_reset();
        test_single_candy();
        test_mixed_order();
        test_zero_request();
        test_jam_fault();
        test_sense_window();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
